rr_hold_arbiter: RTL and testbench
==================================

// Module: rr_hold_arbiter
// PURPOSE
//   Registered round-robin arbiter sharing one resource between N requesters.
//   A winner holds its grant until it signals done, drops its request, or exceeds a hold limit.
//   It sits between the requester ports and the shared resource.
//   It replaces the combinational grant path with a one-cycle-latency grant and a watchdog.
// PARAMETERS
//   N         4    number of requesters (>=2)
//   MAX_HOLD  16   max consecutive grant cycles per winner; 0 disables timeout
//   IDW       $clog2(N)  localparam, width of grant_id / err_id
// PORTS
//   clk          in   1    single clock, all logic on posedge
//   rst          in   1    synchronous, active-low reset
//   req          in   N    request per requester, level
//   done         in   1    resource finished current transfer (valid only while busy)
//   grant        out  N    one-hot grant, registered; all-zero when idle
//   grant_id     out  IDW  binary index of current grant (0 when idle)
//   busy         out  1    a grant is active (|grant)
//   timeout_err  out  1    one-cycle pulse: current holder forcibly released
//   err_id       out  IDW  index of last timed-out requester, held until next timeout
// BEHAVIOUR
//   Reset (rst==0 at posedge): grant=0, grant_id=0, busy=0, timeout_err=0, err_id=0,
//     ptr=0 (requester 0 highest priority), hold_cnt=0, state=IDLE.
//     Reset mid-grant drops grant at that edge; no error is flagged.
//   Priority: search starts at ptr and wraps upward (ptr, ptr+1, ... N-1, 0, ...).
//     After requester k is released, ptr=(k+1) mod N, so k becomes lowest priority.
//   FSM IDLE: if |req, the winner is registered into grant at the next edge (1-cycle latency).
//     Go to GRANT with hold_cnt=1. If req==0, stay in IDLE. done is ignored in IDLE.
//   FSM GRANT: a release event occurs on any of:
//     (a) done==1;
//     (b) req[grant_id]==0;
//     (c) MAX_HOLD!=0 && hold_cnt==MAX_HOLD && !done.
//   No release: hold grant, hold_cnt++ (saturates at MAX_HOLD).
//   Release: advance ptr past the holder and re-arbitrate in the same cycle with the updated ptr.
//     The next edge loads the new winner with no idle bubble and hold_cnt=1.
//     If no requests remain, go to IDLE with grant=0.
//     The released requester may win again only if it is the sole requester.
//   Timeout (c): timeout_err=1 for exactly the release edge+1 cycle; err_id=released index.
//     If done and timeout coincide, done wins: no timeout_err.
//   Changes to req while a grant is held never preempt the holder.
//   grant is always one-hot or zero. grant_id and busy are registered with grant (same cycle).
//   Minimum grant length is 1 cycle: done in the first grant cycle releases it.
// TESTING
//   rst=0 for 3 clks with req=4'b1111
//     -> grant=0, busy=0, timeout_err=0 throughout; after release, first grant=4'b0001.
//   From IDLE, req=4'b0100, done pulsed in the 3rd grant cycle
//     -> grant=4'b0100 one clk after req, grant_id=2, grant=0 the clk after done.
//   req=4'b1111 held, done=1 every cycle
//     -> grant sequence 0001,0010,0100,1000,0001 back-to-back, no idle cycles.
//   req=4'b0010 held, done=0, MAX_HOLD=16
//     -> grant=4'b0010 for 16 cycles, then grant=0, timeout_err one-cycle pulse, err_id=1.
//   Same setup, but done=1 in the cycle hold_cnt==16
//     -> normal release, timeout_err stays 0, err_id unchanged.
//   grant=4'b1000 with req=4'b1011, then req[3] drops
//     -> next grant=4'b0001 (ptr wrapped to 0), no error flagged.

Source files
------------

// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter with hold-until-release grants and a hold-time watchdog.
// A grant is kept until done, the holder drops its request, or it is held for MAX_HOLD cycles.
module rr_hold_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           timeout_err,
    output logic [IDW-1:0] err_id
);

    localparam int HCW = $clog2(MAX_HOLD + 2);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic [IDW-1:0]   err_id_q, err_id_d;

    logic             holder_req;
    logic             timeout_hit;
    logic             release_evt;
    logic [IDW-1:0]   next_ptr;
    logic [IDW-1:0]   arb_base;
    logic [N-1:0]     arb_cand;
    logic             arb_go;
    logic             arb_found;
    logic [IDW-1:0]   arb_id;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            err_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            timeout_err_q <= timeout_err_d;
            err_id_q      <= err_id_d;
        end
    end

    // Release detection; done takes precedence over the watchdog.
    always_comb begin
        holder_req  = req[grant_id_q];
        timeout_hit = (state_q == GRANT) && (MAX_HOLD != 0) &&
                      (hold_cnt_q == HCW'(MAX_HOLD)) && !done;
        release_evt = (state_q == GRANT) && (done || !holder_req || timeout_hit);
        next_ptr    = (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + IDW'(1);
        arb_base    = release_evt ? next_ptr : ptr_q;
        // A holder forcibly released by the watchdog sits out the same-cycle re-arbitration.
        arb_cand    = req & ~((release_evt && timeout_hit) ? grant_q : '0);
        arb_go      = (state_q == IDLE) || release_evt;
    end

    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        for (int i = 0; i < N; i++) begin
            if (!arb_found && arb_cand[(int'(arb_base) + i) % N]) begin
                arb_found = 1'b1;
                arb_id    = IDW'((int'(arb_base) + i) % N);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_found) state_d = GRANT;
            GRANT:   if (release_evt && !arb_found) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_err_d = 1'b0;
        err_id_d      = err_id_q;

        if (arb_go && arb_found) begin
            grant_d    = N'(1) << arb_id;
            grant_id_d = arb_id;
            hold_cnt_d = HCW'(1);
        end else if (release_evt) begin
            grant_d    = '0;
            grant_id_d = '0;
            hold_cnt_d = '0;
        end else if ((state_q == GRANT) && (MAX_HOLD != 0) &&
                     (hold_cnt_q != HCW'(MAX_HOLD))) begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
        end

        if (release_evt) ptr_d = next_ptr;

        if (release_evt && timeout_hit) begin
            timeout_err_d = 1'b1;
            err_id_d      = grant_id_q;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign busy        = |grant_q;
    assign timeout_err = timeout_err_q;
    assign err_id      = err_id_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed scoreboard bench for rr_hold_arbiter (N=4, MAX_HOLD=16).
// Each step drives req/done, queues the hand-derived expected outputs, and checks after the edge.
module tb_rr_hold_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_err;
    logic [1:0] err_id;

    logic [9:0] exp_q[$];
    int         n_checks;
    int         n_fail;

    rr_hold_arbiter #(.N(4), .MAX_HOLD(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err),
        .err_id     (err_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word layout: {grant, grant_id, busy, timeout_err, err_id}
    function automatic logic [9:0] mk(input logic [3:0] g, input logic [1:0] id,
                                      input logic te, input logic [1:0] eid);
        return {g, id, |g, te, eid};
    endfunction

    task automatic check_eq(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got={g=%b id=%0d busy=%b terr=%b eid=%0d} exp={g=%b id=%0d busy=%b terr=%b eid=%0d}",
                     tag, obs[9:6], obs[5:4], obs[3], obs[2], obs[1:0],
                     exp[9:6], exp[5:4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] r, input logic d, input logic [9:0] e);
        logic [9:0] got;
        req  = r;
        done = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {grant, grant_id, busy, timeout_err, err_id};
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            check_eq(tag, got, exp_q.pop_front());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b0;
        req  = 4'b1111;
        done = 1'b0;

        // Reset held with all requesting: nothing granted.
        for (int i = 0; i < 3; i++) step("reset", 4'b1111, 1'b0, mk(4'b0000, 2'd0, 1'b0, 2'd0));
        rst = 1'b1;
        step("first_grant", 4'b1111, 1'b0, mk(4'b0001, 2'd0, 1'b0, 2'd0));
        step("release_idle", 4'b0000, 1'b1, mk(4'b0000, 2'd0, 1'b0, 2'd0));   // ptr=1

        // Single requester, done in its third grant cycle.
        step("single_g1", 4'b0100, 1'b0, mk(4'b0100, 2'd2, 1'b0, 2'd0));
        step("single_g2", 4'b0100, 1'b0, mk(4'b0100, 2'd2, 1'b0, 2'd0));
        step("single_g3", 4'b0100, 1'b0, mk(4'b0100, 2'd2, 1'b0, 2'd0));
        step("single_done", 4'b0000, 1'b1, mk(4'b0000, 2'd0, 1'b0, 2'd0));   // ptr=3

        // All requesting with done every cycle: back-to-back rotation from ptr=3.
        step("rot0", 4'b1111, 1'b1, mk(4'b1000, 2'd3, 1'b0, 2'd0));
        step("rot1", 4'b1111, 1'b1, mk(4'b0001, 2'd0, 1'b0, 2'd0));
        step("rot2", 4'b1111, 1'b1, mk(4'b0010, 2'd1, 1'b0, 2'd0));
        step("rot3", 4'b1111, 1'b1, mk(4'b0100, 2'd2, 1'b0, 2'd0));
        step("rot4", 4'b1111, 1'b1, mk(4'b1000, 2'd3, 1'b0, 2'd0));
        step("rot5", 4'b1111, 1'b1, mk(4'b0001, 2'd0, 1'b0, 2'd0));
        step("rot_end", 4'b0000, 1'b1, mk(4'b0000, 2'd0, 1'b0, 2'd0));       // ptr=1

        // Watchdog: requester 1 holds for 16 cycles, then is forced off.
        step("tmo_g1", 4'b0010, 1'b0, mk(4'b0010, 2'd1, 1'b0, 2'd0));
        for (int i = 2; i <= 16; i++) step("tmo_hold", 4'b0010, 1'b0, mk(4'b0010, 2'd1, 1'b0, 2'd0));
        step("tmo_fire", 4'b0010, 1'b0, mk(4'b0000, 2'd0, 1'b1, 2'd1));      // ptr=2
        step("tmo_regrant", 4'b0010, 1'b0, mk(4'b0010, 2'd1, 1'b0, 2'd1));
        step("tmo_drop", 4'b0000, 1'b0, mk(4'b0000, 2'd0, 1'b0, 2'd1));      // ptr=2

        // Done arriving in the limit cycle wins over the watchdog.
        step("dw_g1", 4'b0010, 1'b0, mk(4'b0010, 2'd1, 1'b0, 2'd1));
        for (int i = 2; i <= 16; i++) step("dw_hold", 4'b0010, 1'b0, mk(4'b0010, 2'd1, 1'b0, 2'd1));
        step("dw_done", 4'b0000, 1'b1, mk(4'b0000, 2'd0, 1'b0, 2'd1));       // ptr=2

        // No preemption, then holder drops request and ptr wraps to 0.
        step("np_g3", 4'b1000, 1'b0, mk(4'b1000, 2'd3, 1'b0, 2'd1));
        step("np_hold1", 4'b1011, 1'b0, mk(4'b1000, 2'd3, 1'b0, 2'd1));
        step("np_hold2", 4'b1011, 1'b0, mk(4'b1000, 2'd3, 1'b0, 2'd1));
        step("np_drop", 4'b0011, 1'b0, mk(4'b0001, 2'd0, 1'b0, 2'd1));       // ptr=0
        step("np_hold3", 4'b0011, 1'b0, mk(4'b0001, 2'd0, 1'b0, 2'd1));
        step("np_next", 4'b0011, 1'b1, mk(4'b0010, 2'd1, 1'b0, 2'd1));       // ptr=1
        step("np_idle", 4'b0000, 1'b0, mk(4'b0000, 2'd0, 1'b0, 2'd1));       // ptr=2

        // Random requester while idle, released by done: winner from ptr=2 upward.
        begin
            logic [3:0] r;
            logic [3:0] g;
            logic [1:0] id;
            r = 4'($urandom_range(1, 15));
            g = '0;
            id = '0;
            for (int k = 0; k < 4; k++) begin
                if (g == 4'b0000 && r[(2 + k) % 4]) begin
                    id = 2'((2 + k) % 4);
                    g  = 4'b0001 << id;
                end
            end
            step("rand_grant", r, 1'b0, mk(g, id, 1'b0, 2'd1));
            step("rand_release", 4'b0000, 1'b1, mk(4'b0000, 2'd0, 1'b0, 2'd1));
        end

        // Reset in the middle of a grant clears everything without an error pulse.
        step("mr_grant", 4'b0100, 1'b0, mk(4'b0100, 2'd2, 1'b0, 2'd1));
        rst = 1'b0;
        step("mr_reset", 4'b0100, 1'b0, mk(4'b0000, 2'd0, 1'b0, 2'd0));
        rst = 1'b1;
        step("mr_after", 4'b0101, 1'b0, mk(4'b0001, 2'd0, 1'b0, 2'd0));

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
